load_sequencer: RTL and testbench

//  Sequences the initial load of on-chip memories from the IO streams. Writes CNN weights, then the

---
 rtl/load_seq_pkg.sv | 24 ++
 rtl/load_channel.sv | 55 +++++
 rtl/load_sequencer.sv | 128 ++++++++++++
 tb/tb_load_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/load_seq_pkg.sv
// rtl/load_seq_pkg.sv - shared state types and default word counts for the memory load sequencer
package load_seq_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int CNN_WORDS_DEF = 50704;
    localparam int IMG_WORDS_DEF = 1024;
    localparam int FC_WORDS_DEF  = 11218;
    localparam int CNN_AW_DEF    = 16;
    localparam int FC_AW_DEF     = 14;

    typedef enum logic [1:0] {
        CNN_IDLE,
        LOAD_CNN,
        LOAD_IMG,
        CNN_DONE
    } cnn_state_t;

    typedef enum logic [1:0] {
        FC_IDLE,
        LOAD_FC,
        FC_DONE
    } fc_state_t;

endpackage

// File: rtl/load_channel.sv
// rtl/load_channel.sv - one stream-to-RAM channel: handshake, word counter, registered write port
module load_channel #(
    parameter int COUNT = 8,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int BASE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic          valid,
    input  logic [DW-1:0] data,
    output logic          ready,
    output logic          last,
    output logic          we,
    output logic          wlast,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(COUNT - 1);
    localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);

    logic [AW-1:0] count;
    logic          accept;

    assign ready  = en;
    assign accept = en & valid;
    assign last   = accept && (count == LAST_IDX);

    // Counter parks on the final index; the owning FSM drops en on that same accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            we    <= 1'b0;
            wlast <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            we    <= accept;
            wlast <= last;
            if (clear) begin
                count <= '0;
            end else if (accept && !last) begin
                count <= count + 1'b1;
            end
            if (accept) begin
                addr  <= BASE_ADDR + count;
                wdata <= data;
            end
        end
    end

endmodule

// File: rtl/load_sequencer.sv
// rtl/load_sequencer.sv - loads CNN weights + image into CNN RAM and FC weights into FC RAM
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNN_WORDS = CNN_WORDS_DEF,
    parameter int IMG_WORDS = IMG_WORDS_DEF,
    parameter int FC_WORDS  = FC_WORDS_DEF,
    parameter int CNN_AW    = CNN_AW_DEF,
    parameter int FC_AW     = FC_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cnn_valid,
    input  logic [DATA_W-1:0] cnn_data,
    output logic              cnn_ready,
    input  logic              img_valid,
    input  logic [DATA_W-1:0] img_data,
    output logic              img_ready,
    input  logic              fc_valid,
    input  logic [DATA_W-1:0] fc_data,
    output logic              fc_ready,
    output logic              cnn_we,
    output logic [CNN_AW-1:0] cnn_addr,
    output logic [DATA_W-1:0] cnn_wdata,
    output logic              fc_we,
    output logic [FC_AW-1:0]  fc_addr,
    output logic [DATA_W-1:0] fc_wdata,
    output logic              busy,
    output logic              cnn_loaded,
    output logic              img_loaded,
    output logic              fc_loaded,
    output logic              all_loaded
);

    cnn_state_t cnn_state, cnn_state_next;
    fc_state_t  fc_state,  fc_state_next;

    logic              restart;
    logic              w_last, w_we, w_wlast;
    logic              i_last, i_we, i_wlast;
    logic              f_last, f_wlast;
    logic [CNN_AW-1:0] w_addr, i_addr;
    logic [DATA_W-1:0] w_wdata, i_wdata;
    logic              use_img;

    // A new load only begins from a quiescent pair: both idle or both finished.
    assign restart = start &&
                     (((cnn_state == CNN_IDLE) && (fc_state == FC_IDLE)) ||
                      ((cnn_state == CNN_DONE) && (fc_state == FC_DONE)));

    load_channel #(.COUNT(CNN_WORDS), .AW(CNN_AW), .DW(DATA_W), .BASE(0)) u_cnn (
        .clk(clk), .rst(rst), .en(cnn_state == LOAD_CNN), .clear(restart),
        .valid(cnn_valid), .data(cnn_data), .ready(cnn_ready), .last(w_last),
        .we(w_we), .wlast(w_wlast), .addr(w_addr), .wdata(w_wdata)
    );

    load_channel #(.COUNT(IMG_WORDS), .AW(CNN_AW), .DW(DATA_W), .BASE(CNN_WORDS)) u_img (
        .clk(clk), .rst(rst), .en(cnn_state == LOAD_IMG), .clear(restart),
        .valid(img_valid), .data(img_data), .ready(img_ready), .last(i_last),
        .we(i_we), .wlast(i_wlast), .addr(i_addr), .wdata(i_wdata)
    );

    load_channel #(.COUNT(FC_WORDS), .AW(FC_AW), .DW(DATA_W), .BASE(0)) u_fc (
        .clk(clk), .rst(rst), .en(fc_state == LOAD_FC), .clear(restart),
        .valid(fc_valid), .data(fc_data), .ready(fc_ready), .last(f_last),
        .we(fc_we), .wlast(f_wlast), .addr(fc_addr), .wdata(fc_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnn_state <= CNN_IDLE;
            fc_state  <= FC_IDLE;
        end else begin
            cnn_state <= cnn_state_next;
            fc_state  <= fc_state_next;
        end
    end

    always_comb begin
        cnn_state_next = cnn_state;
        fc_state_next  = fc_state;
        case (cnn_state)
            CNN_IDLE, CNN_DONE: if (restart) cnn_state_next = LOAD_CNN;
            LOAD_CNN:           if (w_last)  cnn_state_next = LOAD_IMG;
            LOAD_IMG:           if (i_last)  cnn_state_next = CNN_DONE;
            default:                         cnn_state_next = CNN_IDLE;
        endcase
        case (fc_state)
            FC_IDLE, FC_DONE:   if (restart) fc_state_next = LOAD_FC;
            LOAD_FC:            if (f_last)  fc_state_next = FC_DONE;
            default:                         fc_state_next = FC_IDLE;
        endcase
    end

    // Port select follows whichever channel wrote last, so addr/wdata hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            use_img    <= 1'b0;
            cnn_loaded <= 1'b0;
            img_loaded <= 1'b0;
            fc_loaded  <= 1'b0;
        end else begin
            if (img_valid && img_ready) begin
                use_img <= 1'b1;
            end else if (cnn_valid && cnn_ready) begin
                use_img <= 1'b0;
            end
            if (restart) begin
                cnn_loaded <= 1'b0;
                img_loaded <= 1'b0;
                fc_loaded  <= 1'b0;
            end else begin
                cnn_loaded <= cnn_loaded | w_wlast;
                img_loaded <= img_loaded | i_wlast;
                fc_loaded  <= fc_loaded  | f_wlast;
            end
        end
    end

    assign cnn_we     = w_we | i_we;
    assign cnn_addr   = use_img ? i_addr  : w_addr;
    assign cnn_wdata  = use_img ? i_wdata : w_wdata;
    assign busy       = (cnn_state == LOAD_CNN) || (cnn_state == LOAD_IMG) || (fc_state == LOAD_FC);
    assign all_loaded = img_loaded & fc_loaded;

endmodule

// File: tb/tb_load_sequencer.sv
// tb/tb_load_sequencer.sv - directed table, random stalls and reset cases against a word-count model
module tb_load_sequencer;

    localparam int DW = 16, CW = 8, IW = 4, FW = 6, CAW = 16, FAW = 14;

    logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic           cnn_valid = 1'b0, img_valid = 1'b0, fc_valid = 1'b0;
    logic [DW-1:0]  cnn_data = '0, img_data = '0, fc_data = '0;
    logic           cnn_ready, img_ready, fc_ready, cnn_we, fc_we;
    logic [CAW-1:0] cnn_addr;
    logic [FAW-1:0] fc_addr;
    logic [DW-1:0]  cnn_wdata, fc_wdata;
    logic           busy, cnn_loaded, img_loaded, fc_loaded, all_loaded;

    load_sequencer #(.DATA_W(DW), .CNN_WORDS(CW), .IMG_WORDS(IW), .FC_WORDS(FW),
                     .CNN_AW(CAW), .FC_AW(FAW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cnn_valid(cnn_valid), .cnn_data(cnn_data), .cnn_ready(cnn_ready),
        .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
        .fc_valid(fc_valid), .fc_data(fc_data), .fc_ready(fc_ready),
        .cnn_we(cnn_we), .cnn_addr(cnn_addr), .cnn_wdata(cnn_wdata),
        .fc_we(fc_we), .fc_addr(fc_addr), .fc_wdata(fc_wdata),
        .busy(busy), .cnn_loaded(cnn_loaded), .img_loaded(img_loaded),
        .fc_loaded(fc_loaded), .all_loaded(all_loaded)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // Model: words accepted per stream, words written per region, last expected write port values.
    bit m_started;
    int m_cnn, m_img, m_fc, wr_cnn, wr_img, wr_fc;
    bit e_cwe, e_fwe;
    int e_caddr, e_cdata, e_faddr, e_fdata;

    typedef struct {
        bit st;
        bit c_we;
        int c_addr;
        bit f_we;
        int f_addr;
        bit c_ld, i_ld, f_ld, bsy;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic bit m_done();
        return m_cnn == CW && m_img == IW && m_fc == FW;
    endfunction

    task automatic model_reset();
        m_started = 0; m_cnn = 0; m_img = 0; m_fc = 0;
        wr_cnn = 0; wr_img = 0; wr_fc = 0;
        e_cwe = 0; e_fwe = 0; e_caddr = 0; e_cdata = 0; e_faddr = 0; e_fdata = 0;
    endtask

    task automatic check_model();
        chk("cnn_ready",  cnn_ready,  m_started && m_cnn < CW);
        chk("img_ready",  img_ready,  m_started && m_cnn == CW && m_img < IW);
        chk("fc_ready",   fc_ready,   m_started && m_fc < FW);
        chk("cnn_we",     cnn_we,     e_cwe);
        chk("cnn_addr",   cnn_addr,   e_caddr);
        chk("cnn_wdata",  cnn_wdata,  e_cdata);
        chk("fc_we",      fc_we,      e_fwe);
        chk("fc_addr",    fc_addr,    e_faddr);
        chk("fc_wdata",   fc_wdata,   e_fdata);
        chk("busy",       busy,       m_started && !m_done());
        chk("cnn_loaded", cnn_loaded, wr_cnn == CW);
        chk("img_loaded", img_loaded, wr_img == IW);
        chk("fc_loaded",  fc_loaded,  wr_fc == FW);
        chk("all_loaded", all_loaded, wr_img == IW && wr_fc == FW);
    endtask

    task automatic step(input bit st, input bit cv, input bit iv, input bit fv);
        bit acc_c, acc_i, acc_f, do_rs;
        start = st; cnn_valid = cv; img_valid = iv; fc_valid = fv;
        cnn_data = DW'($urandom); img_data = DW'($urandom); fc_data = DW'($urandom);
        do_rs = st && (!m_started || m_done());
        acc_c = cv && m_started && m_cnn < CW;
        acc_i = iv && m_started && m_cnn == CW && m_img < IW;
        acc_f = fv && m_started && m_fc < FW;
        if (e_cwe) begin
            if (e_caddr < CW) wr_cnn++;
            else wr_img++;
        end
        if (e_fwe) wr_fc++;
        e_cwe = acc_c || acc_i;
        e_fwe = acc_f;
        if (acc_c) begin e_caddr = m_cnn; e_cdata = int'(cnn_data); m_cnn++; end
        if (acc_i) begin e_caddr = CW + m_img; e_cdata = int'(img_data); m_img++; end
        if (acc_f) begin e_faddr = m_fc; e_fdata = int'(fc_data); m_fc++; end
        if (do_rs) begin
            m_started = 1; m_cnn = 0; m_img = 0; m_fc = 0;
            wr_cnn = 0; wr_img = 0; wr_fc = 0;
        end
        @(posedge clk);
        #1;
        check_model();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string nm);
        for (int c = 0; c < 400 && !m_done(); c++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
        chk(nm, m_done(), 1);
        repeat (3) step($urandom_range(0, 1) == 0 && 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        //          st c_we c_addr f_we f_addr c_ld i_ld f_ld busy
        tbl[0]  = '{1'b1, 1'b0,  0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1,  0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1,  1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1,  2, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1,  3, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1,  4, 1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1,  5, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1,  6, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1,  7, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1,  8, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1,  9, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 10, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 11, 1'b0, 5, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 11, 1'b0, 5, 1'b1, 1'b1, 1'b1, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        rst = 1'b0;

        // Streaming load with every valid held high, image valid from the start.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].st, 1'b1, 1'b1, 1'b1);
            chk($sformatf("tbl%0d_cnn_we", i),     cnn_we,     tbl[i].c_we);
            chk($sformatf("tbl%0d_cnn_addr", i),   cnn_addr,   tbl[i].c_addr);
            chk($sformatf("tbl%0d_fc_we", i),      fc_we,      tbl[i].f_we);
            chk($sformatf("tbl%0d_fc_addr", i),    fc_addr,    tbl[i].f_addr);
            chk($sformatf("tbl%0d_cnn_loaded", i), cnn_loaded, tbl[i].c_ld);
            chk($sformatf("tbl%0d_img_loaded", i), img_loaded, tbl[i].i_ld);
            chk($sformatf("tbl%0d_fc_loaded", i),  fc_loaded,  tbl[i].f_ld);
            chk($sformatf("tbl%0d_busy", i),       busy,       tbl[i].bsy);
        end

        // Restart after completion, then a start pulse mid-load that must be ignored.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("restart_flags_clear", {cnn_loaded, img_loaded, fc_loaded, all_loaded}, 0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("restart_addr2", cnn_addr, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midload_start_addr3", cnn_addr, 3);
        chk("midload_start_busy", busy, 1);
        run_until_done("midload_finish");

        // Random stalls across several complete loads.
        for (int l = 0; l < 4; l++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            run_until_done($sformatf("random_load%0d_done", l));
        end

        // Asynchronous reset partway through the image.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 400 && !(m_cnn == CW && m_img == 2); c++)
            step(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        chk("reach_mid_image", m_img, 2);
        rst = 1'b1;
        #2;
        chk("async_rst_zero", |{cnn_ready, img_ready, fc_ready, cnn_we, cnn_addr, cnn_wdata,
                                fc_we, fc_addr, fc_wdata, busy, cnn_loaded, img_loaded,
                                fc_loaded, all_loaded}, 0);
        model_reset();
        check_model();
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("post_rst_cnn_addr0", cnn_addr, 0);
        chk("post_rst_cnn_we", cnn_we, 1);
        run_until_done("post_rst_done");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
